// File: rtl/operand_scoreboard_if.sv
// operand_scoreboard_if
//   Groups the decode-side hazard/forwarding signals of operand_scoreboard.
//   master : decode stage / pipeline (drives DE_*, RF_*, ADV, STG_*)
//   slave  : the scoreboard itself (drives OP*, FWD_SEL*, HAZARD_STALL,
//            ISSUE, STALL_COUNT, ENT_IS_LOAD)
//   ENT_IS_LOAD is a debug view of the per-entry is_load bits.
interface operand_scoreboard_if #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned RA_W  = 5,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned CNT_W = 32
);
  logic                    DE_V;
  logic [RA_W-1:0]         DE_RS1;
  logic [RA_W-1:0]         DE_RS2;
  logic                    DE_RS1_USED;
  logic                    DE_RS2_USED;
  logic [RA_W-1:0]         DE_RD;
  logic                    DE_RD_WE;
  logic                    DE_IS_LOAD;
  logic [XLEN-1:0]         RF_RS1_DATA;
  logic [XLEN-1:0]         RF_RS2_DATA;
  logic                    ADV;
  logic [DEPTH*XLEN-1:0]   STG_DATA;
  logic [DEPTH-1:0]        STG_DATA_V;
  logic [XLEN-1:0]         OP1;
  logic [XLEN-1:0]         OP2;
  logic [3:0]              FWD_SEL1;
  logic [3:0]              FWD_SEL2;
  logic                    HAZARD_STALL;
  logic                    ISSUE;
  logic [CNT_W-1:0]        STALL_COUNT;
  logic [DEPTH-1:0]        ENT_IS_LOAD;

  modport master (
    output DE_V, DE_RS1, DE_RS2, DE_RS1_USED, DE_RS2_USED, DE_RD, DE_RD_WE,
           DE_IS_LOAD, RF_RS1_DATA, RF_RS2_DATA, ADV, STG_DATA, STG_DATA_V,
    input  OP1, OP2, FWD_SEL1, FWD_SEL2, HAZARD_STALL, ISSUE, STALL_COUNT,
           ENT_IS_LOAD
  );

  modport slave (
    input  DE_V, DE_RS1, DE_RS2, DE_RS1_USED, DE_RS2_USED, DE_RD, DE_RD_WE,
           DE_IS_LOAD, RF_RS1_DATA, RF_RS2_DATA, ADV, STG_DATA, STG_DATA_V,
    output OP1, OP2, FWD_SEL1, FWD_SEL2, HAZARD_STALL, ISSUE, STALL_COUNT,
           ENT_IS_LOAD
  );
endinterface

// File: rtl/operand_scoreboard.sv
// operand_scoreboard
//   Decode-stage operand hazard and forwarding unit. Tracks register writers
//   in DEPTH downstream stages (entry 0 = EXE ... DEPTH-1 = WB), forwards the
//   youngest matching result to both operands and stalls decode when that
//   youngest producer has no data yet.
//   Ports:
//     CLK   - clock
//     RESET - asynchronous active-high reset
//     bus   - operand_scoreboard_if.slave (decode inputs, stage results,
//             forwarded operands, selects, stall/issue, stall counter)
module operand_scoreboard #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned RA_W  = 5,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned CNT_W = 32
) (
  input  logic                 CLK,
  input  logic                 RESET,
  operand_scoreboard_if.slave  bus
);

  logic [DEPTH-1:0] r_v;
  logic [DEPTH-1:0] r_ld;
  logic [RA_W-1:0]  r_rd [DEPTH];
  logic [CNT_W-1:0] r_cnt;

  logic             w_hit1, w_hit2;
  logic             w_blk1, w_blk2;
  logic [3:0]       w_sel1, w_sel2;
  logic [XLEN-1:0]  w_op1,  w_op2;
  logic             w_stall;
  logic             w_issue;
  logic             w_load_e0;

  // Scan from entry 0 upward; the first hit is the youngest producer and
  // decides the source, even if an older entry already has data.
  always_comb begin
    w_hit1 = 1'b0;
    w_blk1 = 1'b0;
    w_sel1 = '0;
    w_op1  = bus.RF_RS1_DATA;
    w_hit2 = 1'b0;
    w_blk2 = 1'b0;
    w_sel2 = '0;
    w_op2  = bus.RF_RS2_DATA;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (!w_hit1 && r_v[k] && bus.DE_RS1_USED && (bus.DE_RS1 != '0) &&
          (r_rd[k] == bus.DE_RS1)) begin
        w_hit1 = 1'b1;
        if (bus.STG_DATA_V[k]) begin
          w_sel1 = 4'(k + 1);
          w_op1  = bus.STG_DATA[k*XLEN +: XLEN];
        end else begin
          w_blk1 = 1'b1;
        end
      end
      if (!w_hit2 && r_v[k] && bus.DE_RS2_USED && (bus.DE_RS2 != '0) &&
          (r_rd[k] == bus.DE_RS2)) begin
        w_hit2 = 1'b1;
        if (bus.STG_DATA_V[k]) begin
          w_sel2 = 4'(k + 1);
          w_op2  = bus.STG_DATA[k*XLEN +: XLEN];
        end else begin
          w_blk2 = 1'b1;
        end
      end
    end
  end

  assign w_stall   = bus.DE_V && (w_blk1 || w_blk2);
  assign w_issue   = bus.DE_V && !w_stall && bus.ADV;
  assign w_load_e0 = w_issue && bus.DE_RD_WE && (bus.DE_RD != '0);

  // Entries only move when the downstream pipeline advances; a stalled
  // decode slot turns into a bubble in entry 0.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_v  <= '0;
      r_ld <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) r_rd[k] <= '0;
    end else if (bus.ADV) begin
      for (int unsigned k = 1; k < DEPTH; k++) begin
        r_v[k]  <= r_v[k-1];
        r_ld[k] <= r_ld[k-1];
        r_rd[k] <= r_rd[k-1];
      end
      r_v[0]  <= w_load_e0;
      r_ld[0] <= w_load_e0 && bus.DE_IS_LOAD;
      r_rd[0] <= bus.DE_RD;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_cnt <= '0;
    end else if (w_stall && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.OP1          = w_op1;
  assign bus.OP2          = w_op2;
  assign bus.FWD_SEL1     = w_sel1;
  assign bus.FWD_SEL2     = w_sel2;
  assign bus.HAZARD_STALL = w_stall;
  assign bus.ISSUE        = w_issue;
  assign bus.STALL_COUNT  = r_cnt;
  assign bus.ENT_IS_LOAD  = r_ld;

endmodule

// File: tb/tb_operand_scoreboard.sv
module tb_operand_scoreboard;
  localparam int unsigned XLEN  = 64;
  localparam int unsigned RA_W  = 5;
  localparam int unsigned DEPTH = 3;
  localparam int unsigned CNT_W = 32;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  operand_scoreboard_if #(.XLEN(XLEN), .RA_W(RA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus();

  operand_scoreboard #(.XLEN(XLEN), .RA_W(RA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       ld;
  } ent_t;

  ent_t        pipe[$];
  int unsigned exp_cnt;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    ent_t e;
    e.v = 0; e.rd = 0; e.ld = 0;
    pipe.delete();
    for (int i = 0; i < DEPTH; i++) pipe.push_back(e);
    exp_cnt = 0;
  endfunction

  // Youngest valid writer of rs decides the source.
  function automatic void resolve(input bit used, input bit [4:0] rs, input bit [63:0] rf,
                                  output bit [3:0] sel, output bit blk, output bit [63:0] op);
    sel = 0; blk = 0; op = rf;
    if (!used || rs == 0) return;
    for (int k = 0; k < DEPTH; k++) begin
      if (pipe[k].v && pipe[k].rd == rs) begin
        if (bus.STG_DATA_V[k]) begin
          sel = 4'(k + 1);
          op  = bus.STG_DATA[k*XLEN +: XLEN];
        end else begin
          blk = 1;
        end
        return;
      end
    end
  endfunction

  function automatic void model_eval(output bit [3:0] s1, output bit b1, output bit [63:0] o1,
                                     output bit [3:0] s2, output bit b2, output bit [63:0] o2,
                                     output bit stall, output bit issue);
    resolve(bus.DE_RS1_USED, bus.DE_RS1, bus.RF_RS1_DATA, s1, b1, o1);
    resolve(bus.DE_RS2_USED, bus.DE_RS2, bus.RF_RS2_DATA, s2, b2, o2);
    stall = bus.DE_V && (b1 || b2);
    issue = bus.DE_V && !stall && bus.ADV;
  endfunction

  task automatic settle_and_check();
    bit [3:0] s1, s2; bit b1, b2, st, is; bit [63:0] o1, o2;
    bit [DEPTH-1:0] ld;
    #2;
    model_eval(s1, b1, o1, s2, b2, o2, st, is);
    for (int k = 0; k < DEPTH; k++) ld[k] = pipe[k].v && pipe[k].ld;
    check("fwd_sel1", 64'(bus.FWD_SEL1), 64'(s1));
    check("fwd_sel2", 64'(bus.FWD_SEL2), 64'(s2));
    if (!b1) check("op1", bus.OP1, o1);
    if (!b2) check("op2", bus.OP2, o2);
    check("stall", 64'(bus.HAZARD_STALL), 64'(st));
    check("issue", 64'(bus.ISSUE), 64'(is));
    check("stall_count", 64'(bus.STALL_COUNT), 64'(exp_cnt));
    check("is_load", 64'(bus.ENT_IS_LOAD), 64'(ld));
  endtask

  task automatic tick();
    bit [3:0] s1, s2; bit b1, b2, st, is; bit [63:0] o1, o2;
    ent_t e;
    model_eval(s1, b1, o1, s2, b2, o2, st, is);
    @(posedge CLK);
    if (st) exp_cnt++;
    if (bus.ADV) begin
      e.v  = is && bus.DE_RD_WE && (bus.DE_RD != 0);
      e.rd = e.v ? bus.DE_RD : 5'd0;
      e.ld = e.v && bus.DE_IS_LOAD;
      void'(pipe.pop_back());
      pipe.push_front(e);
    end
    #1;
  endtask

  task automatic idle_inputs();
    bus.DE_V = 0; bus.DE_RS1 = 0; bus.DE_RS2 = 0;
    bus.DE_RS1_USED = 0; bus.DE_RS2_USED = 0;
    bus.DE_RD = 0; bus.DE_RD_WE = 0; bus.DE_IS_LOAD = 0;
    bus.RF_RS1_DATA = 64'h1111; bus.RF_RS2_DATA = 64'h2222;
    bus.ADV = 1; bus.STG_DATA = '0; bus.STG_DATA_V = '1;
  endtask

  task automatic do_reset();
    RESET = 1;
    #1;
    model_reset();
    settle_and_check();
    check("rst_sel1", 64'(bus.FWD_SEL1), 64'd0);
    check("rst_count", 64'(bus.STALL_COUNT), 64'd0);
    @(negedge CLK);
    RESET = 0;
    @(posedge CLK);
    #1;
  endtask

  task automatic issue_writer(input bit [4:0] rd, input bit ld);
    idle_inputs();
    bus.DE_V = 1; bus.DE_RD = rd; bus.DE_RD_WE = 1; bus.DE_IS_LOAD = ld;
    settle_and_check();
    tick();
  endtask

  int unsigned c0;

  initial begin
    idle_inputs();
    model_reset();
    @(posedge CLK); #1;
    do_reset();

    // ALU back-to-back
    issue_writer(5'd5, 0);
    idle_inputs();
    bus.DE_V = 1; bus.DE_RS1 = 5; bus.DE_RS2 = 5; bus.DE_RS1_USED = 1; bus.DE_RS2_USED = 1;
    bus.STG_DATA_V = 3'b001; bus.STG_DATA[63:0] = 64'h1234;
    settle_and_check();
    check("b2b_op1", bus.OP1, 64'h1234);
    check("b2b_op2", bus.OP2, 64'h1234);
    check("b2b_sel1", 64'(bus.FWD_SEL1), 64'd1);
    check("b2b_sel2", 64'(bus.FWD_SEL2), 64'd1);
    check("b2b_stall", 64'(bus.HAZARD_STALL), 64'd0);
    tick();

    // Load-use
    do_reset();
    issue_writer(5'd7, 1);
    idle_inputs();
    bus.DE_V = 1; bus.DE_RS2 = 7; bus.DE_RS2_USED = 1; bus.STG_DATA_V = 3'b000;
    settle_and_check();
    check("lu_stall", 64'(bus.HAZARD_STALL), 64'd1);
    check("lu_issue", 64'(bus.ISSUE), 64'd0);
    tick();
    bus.STG_DATA_V = 3'b010; bus.STG_DATA[127:64] = 64'hBEEF;
    settle_and_check();
    check("lu_stall2", 64'(bus.HAZARD_STALL), 64'd0);
    check("lu_sel2", 64'(bus.FWD_SEL2), 64'd2);
    check("lu_op2", bus.OP2, 64'hBEEF);
    check("lu_count", 64'(bus.STALL_COUNT), 64'd1);
    tick();

    // Youngest wins
    do_reset();
    issue_writer(5'd3, 0);
    issue_writer(5'd9, 0);
    issue_writer(5'd3, 0);
    idle_inputs();
    bus.DE_V = 1; bus.DE_RS1 = 3; bus.DE_RS1_USED = 1; bus.STG_DATA_V = 3'b111;
    bus.STG_DATA = {64'hC, 64'hB, 64'hA};
    settle_and_check();
    check("yw_op1", bus.OP1, 64'hA);
    check("yw_sel1", 64'(bus.FWD_SEL1), 64'd1);
    bus.STG_DATA_V = 3'b110;
    settle_and_check();
    check("yw_blocked", 64'(bus.HAZARD_STALL), 64'd1);
    bus.ADV = 0;
    tick();

    // x0 writer and unused source
    do_reset();
    issue_writer(5'd0, 0);
    idle_inputs();
    bus.DE_V = 1; bus.DE_RS1 = 0; bus.DE_RS1_USED = 1; bus.STG_DATA_V = 3'b111;
    settle_and_check();
    check("x0_sel1", 64'(bus.FWD_SEL1), 64'd0);
    check("x0_op1", bus.OP1, 64'h1111);
    tick();
    issue_writer(5'd4, 1);
    idle_inputs();
    bus.DE_V = 1; bus.DE_RS2 = 4; bus.DE_RS2_USED = 0; bus.STG_DATA_V = 3'b000;
    bus.RF_RS2_DATA = 64'h55;
    settle_and_check();
    check("unused_stall", 64'(bus.HAZARD_STALL), 64'd0);
    check("unused_op2", bus.OP2, 64'h55);
    check("unused_sel2", 64'(bus.FWD_SEL2), 64'd0);
    tick();

    // Downstream stall
    do_reset();
    issue_writer(5'd6, 1);
    idle_inputs();
    bus.DE_V = 1; bus.DE_RS1 = 6; bus.DE_RS1_USED = 1; bus.STG_DATA_V = 3'b000; bus.ADV = 0;
    c0 = bus.STALL_COUNT;
    for (int i = 0; i < 3; i++) begin
      settle_and_check();
      check("ds_issue", 64'(bus.ISSUE), 64'd0);
      check("ds_stall", 64'(bus.HAZARD_STALL), 64'd1);
      tick();
    end
    bus.STG_DATA_V = 3'b001; bus.STG_DATA[63:0] = 64'h77;
    settle_and_check();
    check("ds_count", 64'(bus.STALL_COUNT), 64'(c0 + 3));
    check("ds_sel1", 64'(bus.FWD_SEL1), 64'd1);
    check("ds_op1", bus.OP1, 64'h77);
    tick();

    // Asynchronous reset mid-stall
    do_reset();
    issue_writer(5'd8, 1);
    idle_inputs();
    bus.DE_V = 1; bus.DE_RS1 = 8; bus.DE_RS2 = 8; bus.DE_RS1_USED = 1; bus.DE_RS2_USED = 1;
    bus.STG_DATA_V = 3'b000; bus.ADV = 0;
    settle_and_check();
    tick();
    settle_and_check();
    check("ar_pre_stall", 64'(bus.HAZARD_STALL), 64'd1);
    RESET = 1;
    #1;
    model_reset();
    check("ar_stall", 64'(bus.HAZARD_STALL), 64'd0);
    check("ar_count", 64'(bus.STALL_COUNT), 64'd0);
    check("ar_sel1", 64'(bus.FWD_SEL1), 64'd0);
    check("ar_sel2", 64'(bus.FWD_SEL2), 64'd0);
    check("ar_op1", bus.OP1, 64'h1111);
    @(negedge CLK);
    RESET = 0;
    @(posedge CLK); #1;

    // Randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      bus.DE_V        = ($urandom_range(0, 9) < 8);
      bus.DE_RS1      = 5'($urandom_range(0, 7));
      bus.DE_RS2      = 5'($urandom_range(0, 7));
      bus.DE_RS1_USED = $urandom_range(0, 3) != 0;
      bus.DE_RS2_USED = $urandom_range(0, 3) != 0;
      bus.DE_RD       = 5'($urandom_range(0, 7));
      bus.DE_RD_WE    = $urandom_range(0, 3) != 0;
      bus.DE_IS_LOAD  = $urandom_range(0, 2) == 0;
      bus.RF_RS1_DATA = {$urandom, $urandom};
      bus.RF_RS2_DATA = {$urandom, $urandom};
      bus.ADV         = $urandom_range(0, 3) != 0;
      bus.STG_DATA    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      bus.STG_DATA_V  = 3'($urandom);
      settle_and_check();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/operand_scoreboard.md
# operand_scoreboard

Parametrised operand-hazard and forwarding unit for the decode stage. It tracks every in-flight register writer across `DEPTH` downstream pipeline stages and forwards the youngest available result to both source operands. When the youngest matching producer has no data yet (load-use), it holds decode and inserts a bubble. It sits between the register file read ports and the EXE input latches, and replaces per-stage, rs1-only forwarding equations with a generic N-stage, two-operand scheme.

## Interface
- `XLEN`, 64, operand/result width
- `RA_W`, 5, register address width (register 0 hard-wired zero)
- `DEPTH`, 3, downstream stages tracked (entry 0 = EXE, entry DEPTH-1 = WB); legal 1..8
- `CNT_W`, 32, stall counter width
- `CLK` in 1 — clock
- `RESET` in 1 — asynchronous, active-high reset
- `DE_V` in 1 — decode holds a valid instruction
- `DE_RS1`, `DE_RS2` in RA_W — source register numbers
- `DE_RS1_USED`, `DE_RS2_USED` in 1 — source is actually read by the instruction
- `DE_RD` in RA_W — destination register
- `DE_RD_WE` in 1 — instruction writes `DE_RD`
- `DE_IS_LOAD` in 1 — result is produced by memory, not by EXE
- `RF_RS1_DATA`, `RF_RS2_DATA` in XLEN — register file read data
- `ADV` in 1 — downstream pipeline advances this cycle (low = memory stall)
- `STG_DATA` in DEPTH*XLEN — result currently held by stage k, in slice [k*XLEN +: XLEN]
- `STG_DATA_V` in DEPTH — slice k is valid (result computed)
- `OP1`, `OP2` out XLEN — forwarded operand values
- `FWD_SEL1`, `FWD_SEL2` out 4 — source select: 0 = register file, k+1 = entry k
- `HAZARD_STALL` out 1 — decode must hold
- `ISSUE` out 1 — `DE_V && !HAZARD_STALL && ADV`
- `STALL_COUNT` out CNT_W — cycles in which `HAZARD_STALL` was high

## Operation
- Each entry holds a valid bit, `rd`, and `is_load`. Only writers are recorded.
- An entry is written valid only when `DE_RD_WE=1` and `DE_RD!=0`.
- Match for source s at entry k: entry valid, `rd == DE_RSs`, `DE_RSs != 0`, and `DE_RSs_USED=1`.
- Priority: the lowest matching k (youngest) wins. If nothing matches, the source comes from the register file.
- Forward for source s:
  - Youngest match with `STG_DATA_V[k]=1`: `OPs` = slice k and `FWD_SELs` = k+1.
  - Youngest match with `STG_DATA_V[k]=0`: the source is blocked.
- The entry's `is_load` bit has no effect on the forward/stall decision. The stage supplies `STG_DATA_V` and the block trusts it. `is_load` is exported only for debug.
- `HAZARD_STALL` = `DE_V` && (src1 blocked || src2 blocked).
- While a source is blocked, `OPs` falls back to register file data, but the value is don't-care.
- A source with `DE_RSs_USED=0` never stalls and never forwards (`FWD_SELs`=0).
- Update on each posedge CLK:
  - `ADV=0`: all entries hold.
  - `ADV=1`: entry k moves to k+1, and entry DEPTH-1 retires.
  - `ADV=1`, entry 0 loads:
    - the decode instruction's fields if `ISSUE=1`;
    - otherwise a bubble (valid=0).
- `STALL_COUNT` increments when `HAZARD_STALL=1` and saturates at all ones. It counts regardless of `ADV`.

## Timing
- Forwarding, stall, `ISSUE`, and the `FWD_SEL` outputs are combinational from inputs and entry state in the same cycle. No added latency.
- The entry shift is registered, so the issued instruction appears as entry 0 in the next cycle.
- Reset (asynchronous, dominates all events):
  - all entries invalid;
  - `STALL_COUNT`=0;
  - consequently `HAZARD_STALL`=0 and `FWD_SEL1`/`FWD_SEL2`=0;
  - `OP1`/`OP2` = register file data.
- Reset asserted mid-stall clears the stall in the same cycle.
- `ADV=0` together with a hazard: no bubble is inserted. The stall persists until a producer's `STG_DATA_V` rises.
- The same register in several entries: the youngest entry wins even if an older entry has data valid.
- `DE_RS1==DE_RS2`: both operands resolve identically.
- `DEPTH=1` is legal and tracks the EXE stage only.

## Test plan
- **ALU back-to-back.** Entry 0 = {rd=5, valid}, `STG_DATA_V[0]=1`, slice0=0x1234. Decode rs1=5, rs2=5. Required: `OP1`=`OP2`=0x1234, `FWD_SEL1`=`FWD_SEL2`=1, `HAZARD_STALL`=0.
- **Load-use.** Issue a load to rd=7, then decode rs2=7 with `STG_DATA_V[0]=0`. Required:
  - `HAZARD_STALL`=1 for one cycle;
  - a bubble enters entry 0;
  - the next cycle forwards from entry 1 (`FWD_SEL2`=2) with `STG_DATA_V[1]=1`;
  - `STALL_COUNT`=1.
- **Youngest wins.** Entries 0 and 2 both rd=3 with data 0xA and 0xC. Required: `OP1`=0xA, `FWD_SEL1`=1.
- **x0 and unused sources.** A writer with rd=0 is never recorded. Decode rs1=0 with entries holding rd=0 is impossible. `DE_RS2_USED=0` with a matching, blocked entry gives `HAZARD_STALL`=0 and `OP2`=`RF_RS2_DATA`.
- **Downstream stall.** Hold `ADV=0` for 3 cycles while a hazard is present. Required: entries unchanged, `ISSUE`=0, `STALL_COUNT` +3, no bubble inserted.
- **Asynchronous reset.** Assert `RESET` between clock edges mid-stall. Required: `HAZARD_STALL` drops immediately, `STALL_COUNT`=0, all `FWD_SEL`=0.
